// File: rtl/regfile_wb_scheduler_if.sv
// Writeback scheduler bus: ALU/LSU writeback requests, issue-stage hazard query,
// and the register file write port.
interface regfile_wb_scheduler_if #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned REG_NUM   = 32
);
  logic                 alu_valid;
  logic [4:0]           alu_rd;
  logic [DATA_SIZE-1:0] alu_data;
  logic                 lsu_valid;
  logic                 lsu_ready;
  logic [4:0]           lsu_rd;
  logic [DATA_SIZE-1:0] lsu_data;
  logic                 iss_valid;
  logic                 iss_long;
  logic [4:0]           iss_rs1;
  logic [4:0]           iss_rs2;
  logic [4:0]           iss_rd;
  logic                 iss_stall;
  logic                 write_reg;
  logic [4:0]           rd_addr;
  logic [DATA_SIZE-1:0] write_data;
  logic [REG_NUM-1:0]   busy_vec;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_long, iss_rs1, iss_rs2, iss_rd,
    input  lsu_ready, iss_stall, write_reg, rd_addr, write_data, busy_vec
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_long, iss_rs1, iss_rs2, iss_rd,
    output lsu_ready, iss_stall, write_reg, rd_addr, write_data, busy_vec
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Register file write-port scheduler: ALU > buffered LSU > direct LSU arbitration,
// a small LSU return FIFO, and a load scoreboard driving the issue stall.
module regfile_wb_scheduler #(
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned REG_NUM    = 32
) (
  input logic                   clk,
  input logic                   rst,
  regfile_wb_scheduler_if.slave bus
);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic [4:0]           rd;
    logic [DATA_SIZE-1:0] data;
  } entry_t;

  entry_t               mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 fifo_empty, fifo_full, lsu_acc, push, pop, stall;
  logic                 win_valid, win_lsu;
  entry_t               win, lsu_entry;
  logic                 write_reg_q;
  logic [4:0]           rd_addr_q;
  logic [DATA_SIZE-1:0] write_data_q;
  logic [REG_NUM-1:0]   busy_q, busy_d, set_mask, clr_mask;

  assign fifo_empty    = (count_q == '0);
  assign fifo_full     = (count_q == CntW'(FIFO_DEPTH));
  // No bypass: a full FIFO refuses returns even in a cycle that pops.
  assign bus.lsu_ready = rst & ~fifo_full;
  assign lsu_acc       = bus.lsu_valid & bus.lsu_ready;
  assign lsu_entry     = '{rd: bus.lsu_rd, data: bus.lsu_data};

  // busy_q[0] is held at zero, so x0 sources never stall.
  assign stall         = bus.iss_valid &
                         (busy_q[bus.iss_rs1] | busy_q[bus.iss_rs2] | busy_q[bus.iss_rd]);
  assign bus.iss_stall = stall;

  always_comb begin
    win_valid = 1'b0;
    win_lsu   = 1'b0;
    win       = '0;
    push      = 1'b0;
    pop       = 1'b0;
    if (bus.alu_valid) begin
      win_valid = 1'b1;
      win       = '{rd: bus.alu_rd, data: bus.alu_data};
      push      = lsu_acc;
    end else if (!fifo_empty) begin
      win_valid = 1'b1;
      win_lsu   = 1'b1;
      win       = mem_q[rd_ptr_q];
      pop       = 1'b1;
      push      = lsu_acc;
    end else if (lsu_acc) begin
      win_valid = 1'b1;
      win_lsu   = 1'b1;
      win       = lsu_entry;
    end
  end

  // Set is applied after clear so a same-edge set/clear on one register keeps it busy.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.iss_valid && !stall && bus.iss_long && bus.iss_rd != 5'd0) begin
      set_mask[bus.iss_rd] = 1'b1;
    end
    if (win_valid && win_lsu && win.rd != 5'd0) begin
      clr_mask[win.rd] = 1'b1;
    end
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= lsu_entry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      busy_q       <= '0;
      write_reg_q  <= 1'b0;
      rd_addr_q    <= '0;
      write_data_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q     <= count_q + CntW'(push) - CntW'(pop);
      busy_q      <= busy_d;
      // An x0 winner consumes its slot but produces no write.
      write_reg_q <= win_valid && (win.rd != 5'd0);
      if (win_valid && win.rd != 5'd0) begin
        rd_addr_q    <= win.rd;
        write_data_q <= win.data;
      end
    end
  end

  assign bus.write_reg  = write_reg_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.write_data = write_data_q;
  assign bus.busy_vec   = busy_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed vector table, reset
// sequences, and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_regfile_wb_scheduler;
  localparam int unsigned DW = 32;
  localparam int unsigned FD = 2;
  localparam int unsigned RN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_scheduler_if #(.DATA_SIZE(DW), .REG_NUM(RN)) bus ();

  regfile_wb_scheduler #(.DATA_SIZE(DW), .FIFO_DEPTH(FD), .REG_NUM(RN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        iv, il;
    logic [4:0]  rs1, rs2, ird;
    logic        e_ready, e_stall, e_wr;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] adat,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
    input logic iv, input logic il, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] ird, input logic e_ready, input logic e_stall, input logic e_wr,
    input logic [4:0] e_rd, input logic [31:0] e_data, input logic [31:0] e_busy);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat;
    v.iv = iv; v.il = il; v.rs1 = rs1; v.rs2 = rs2; v.ird = ird;
    v.e_ready = e_ready; v.e_stall = e_stall; v.e_wr = e_wr;
    v.e_rd = e_rd; v.e_data = e_data; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic iv, input logic il, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] ird);
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = adat;
    bus.lsu_valid = lv; bus.lsu_rd = lrd; bus.lsu_data = ldat;
    bus.iss_valid = iv; bus.iss_long = il;
    bus.iss_rs1 = rs1; bus.iss_rs2 = rs2; bus.iss_rd = ird;
  endtask

  task automatic drive_idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drive_random();
    drive(1'($urandom), 5'($urandom), $urandom(), 1'($urandom), 5'($urandom), $urandom(),
          1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
  endtask

  // Reference model state
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] mbusy;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed table, starting from an empty FIFO and clear scoreboard.
    vecs.push_back(mk(0,0,0,        0,0,0,        0,0,0,0,0,   1,0,0,0,0,        32'h0));
    // Collision: ALU first, LSU buffered and written next cycle.
    vecs.push_back(mk(1,5,32'h11,   1,6,32'h22,   0,0,0,0,0,   1,0,1,5,32'h11,   32'h0));
    vecs.push_back(mk(0,0,0,        0,0,0,        0,0,0,0,0,   1,0,1,6,32'h22,   32'h0));
    // Backpressure: ALU held three cycles while LSU returns x7, x8, x9.
    vecs.push_back(mk(1,1,32'h101,  1,7,32'hA,    0,0,0,0,0,   1,0,1,1,32'h101,  32'h0));
    vecs.push_back(mk(1,2,32'h102,  1,8,32'hB,    0,0,0,0,0,   1,0,1,2,32'h102,  32'h0));
    vecs.push_back(mk(1,3,32'h103,  1,9,32'hC,    0,0,0,0,0,   0,0,1,3,32'h103,  32'h0));
    vecs.push_back(mk(0,0,0,        1,9,32'hC,    0,0,0,0,0,   0,0,1,7,32'hA,    32'h0));
    vecs.push_back(mk(0,0,0,        1,9,32'hC,    0,0,0,0,0,   1,0,1,8,32'hB,    32'h0));
    vecs.push_back(mk(0,0,0,        0,0,0,        0,0,0,0,0,   1,0,1,9,32'hC,    32'h0));
    // Scoreboard: load to x10, dependent issue stalls until the return.
    vecs.push_back(mk(0,0,0,        0,0,0,        1,1,1,2,10,  1,0,0,0,0,        32'h400));
    vecs.push_back(mk(0,0,0,        0,0,0,        1,0,10,0,11, 1,1,0,0,0,        32'h400));
    vecs.push_back(mk(0,0,0,        1,10,32'h55,  1,0,10,0,11, 1,1,1,10,32'h55,  32'h0));
    vecs.push_back(mk(0,0,0,        0,0,0,        1,0,10,0,11, 1,0,0,0,0,        32'h0));
    // x0: load issue to x0, returns to x0 direct and buffered.
    vecs.push_back(mk(0,0,0,        0,0,0,        1,1,0,0,0,   1,0,0,0,0,        32'h0));
    vecs.push_back(mk(0,0,0,        1,0,32'h77,   0,0,0,0,0,   1,0,0,0,0,        32'h0));
    vecs.push_back(mk(1,4,32'h44,   1,0,32'h66,   0,0,0,0,0,   1,0,1,4,32'h44,   32'h0));
    vecs.push_back(mk(0,0,0,        1,12,32'h12,  0,0,0,0,0,   1,0,0,0,0,        32'h0));
    vecs.push_back(mk(0,0,0,        0,0,0,        0,0,0,0,0,   1,0,1,12,32'h12,  32'h0));
    // Set/clear interaction and stall gating by iss_valid.
    vecs.push_back(mk(0,0,0,        0,0,0,        1,1,0,0,13,  1,0,0,0,0,        32'h2000));
    vecs.push_back(mk(0,0,0,        0,0,0,        0,0,13,13,13,1,0,0,0,0,        32'h2000));
    vecs.push_back(mk(0,0,0,        1,13,32'h13,  1,1,0,0,14,  1,0,1,13,32'h13,  32'h4000));
    vecs.push_back(mk(0,0,0,        1,15,32'h15,  1,1,0,0,15,  1,0,1,15,32'h15,  32'hC000));
    vecs.push_back(mk(0,0,0,        1,14,32'h14,  0,0,0,0,0,   1,0,1,14,32'h14,  32'h8000));
    vecs.push_back(mk(0,0,0,        1,15,32'h16,  1,0,15,0,1,  1,1,1,15,32'h16,  32'h0));
    vecs.push_back(mk(0,0,0,        0,0,0,        1,0,15,0,1,  1,0,0,0,0,        32'h0));

    // Power-on reset with random inputs.
    rst = 1'b0;
    drive_random();
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rst lsu_ready", bus.lsu_ready, 1'b0);
      check("rst write_reg", bus.write_reg, 1'b0);
      check("rst busy_vec", bus.busy_vec, 32'h0);
      @(posedge clk); #1;
      drive_random();
      #1;
    end
    check("rst rd_addr", bus.rd_addr, 5'd0);
    check("rst write_data", bus.write_data, 32'h0);
    drive_idle();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("post-rst lsu_ready", bus.lsu_ready, 1'b1);
    check("post-rst write_reg", bus.write_reg, 1'b0);
    check("post-rst busy_vec", bus.busy_vec, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].lv, vecs[i].lrd, vecs[i].ldat,
            vecs[i].iv, vecs[i].il, vecs[i].rs1, vecs[i].rs2, vecs[i].ird);
      #2;
      check($sformatf("v%0d lsu_ready", i), bus.lsu_ready, vecs[i].e_ready);
      check($sformatf("v%0d iss_stall", i), bus.iss_stall, vecs[i].e_stall);
      @(posedge clk); #1;
      check($sformatf("v%0d write_reg", i), bus.write_reg, vecs[i].e_wr);
      if (vecs[i].e_wr) begin
        check($sformatf("v%0d rd_addr", i), bus.rd_addr, vecs[i].e_rd);
        check($sformatf("v%0d write_data", i), bus.write_data, vecs[i].e_data);
      end
      check($sformatf("v%0d busy_vec", i), bus.busy_vec, vecs[i].e_busy);
    end

    // Reset mid-operation: two buffered loads and busy x3 are discarded.
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 3);
    @(posedge clk); #1;
    check("mid busy x3", bus.busy_vec, 32'h8);
    drive(1, 1, 32'h1, 1, 20, 32'h20, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 2, 32'h2, 1, 21, 32'h21, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 3, 32'h3, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("mid full lsu_ready", bus.lsu_ready, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    check("mid rst write_reg", bus.write_reg, 1'b0);
    check("mid rst busy_vec", bus.busy_vec, 32'h0);
    check("mid rst lsu_ready", bus.lsu_ready, 1'b0);
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("mid drain%0d write_reg", i), bus.write_reg, 1'b0);
      check($sformatf("mid drain%0d busy_vec", i), bus.busy_vec, 32'h0);
      check($sformatf("mid drain%0d lsu_ready", i), bus.lsu_ready, 1'b1);
    end

    // Randomized traffic against the reference model.
    mq.delete();
    mbusy = '0;
    for (int c = 0; c < 3000; c++) begin
      ent_t        w;
      logic        have, from_lsu, exp_ready, exp_stall, exp_wr;
      logic        av, lv, iv, il;
      logic [4:0]  ard, lrd, rs1, rs2, ird;
      logic [31:0] adat, ldat;
      av  = ($urandom_range(0, 2) == 0);
      lv  = ($urandom_range(0, 1) == 0);
      iv  = ($urandom_range(0, 4) < 3);
      il  = ($urandom_range(0, 1) == 0);
      ard = 5'($urandom_range(0, 7)); lrd = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      ird = 5'($urandom_range(0, 7));
      adat = $urandom(); ldat = $urandom();
      drive(av, ard, adat, lv, lrd, ldat, iv, il, rs1, rs2, ird);
      #2;
      exp_ready = (mq.size() < FD);
      exp_stall = iv && (mbusy[rs1] || mbusy[rs2] || mbusy[ird]);
      check($sformatf("r%0d lsu_ready", c), bus.lsu_ready, exp_ready);
      check($sformatf("r%0d iss_stall", c), bus.iss_stall, exp_stall);
      // An accepted return joins the back of the queue; an empty queue means it
      // is also the head, which covers the direct path.
      if (lv && exp_ready) mq.push_back('{rd: lrd, data: ldat});
      have     = 1'b0;
      from_lsu = 1'b0;
      w        = '{rd: 5'd0, data: 32'h0};
      if (av) begin
        w    = '{rd: ard, data: adat};
        have = 1'b1;
      end else if (mq.size() > 0) begin
        w        = mq.pop_front();
        have     = 1'b1;
        from_lsu = 1'b1;
      end
      if (have && from_lsu && w.rd != 5'd0) mbusy[w.rd] = 1'b0;
      if (iv && !exp_stall && il && ird != 5'd0) mbusy[ird] = 1'b1;
      exp_wr = have && (w.rd != 5'd0);
      @(posedge clk); #1;
      check($sformatf("r%0d write_reg", c), bus.write_reg, exp_wr);
      if (exp_wr) begin
        check($sformatf("r%0d rd_addr", c), bus.rd_addr, w.rd);
        check($sformatf("r%0d write_data", c), bus.write_data, w.data);
      end
      check($sformatf("r%0d busy_vec", c), bus.busy_vec, mbusy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Controller for the 32x32 integer register file's single write port.
- Arbitrates writeback between the single-cycle ALU path and the variable-latency load/store unit (LSU) return path. LSU returns that lose arbitration are buffered in a small FIFO.
- Keeps a pending-write scoreboard for long-latency destinations and raises an issue stall on RAW/WAW hazards.
- Sits between the execute/memory stages and the register file write inputs (write_reg, rd_addr, write_data).

Parameters:
- DATA_SIZE, 32, writeback data width.
- FIFO_DEPTH, 2, LSU return buffer entries (power of two, at least 2).
- REG_NUM, 32, architectural registers; addresses are 5 bits; register 0 is hardwired zero.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low.
- alu_valid  input  1  ALU writeback request; always accepted.
- alu_rd  input  5  ALU destination register.
- alu_data  input  DATA_SIZE  ALU result.
- lsu_valid  input  1  LSU load-return request.
- lsu_ready  output  1  LSU return accepted this cycle when high together with lsu_valid.
- lsu_rd  input  5  load destination register.
- lsu_data  input  DATA_SIZE  load data.
- iss_valid  input  1  instruction in issue stage.
- iss_long  input  1  issuing instruction is a load (long latency).
- iss_rs1  input  5  issuing instruction source 1.
- iss_rs2  input  5  issuing instruction source 2.
- iss_rd  input  5  issuing instruction destination.
- iss_stall  output  1  hold issue stage.
- write_reg  output  1  register file write enable (registered).
- rd_addr  output  5  register file write address (registered).
- write_data  output  DATA_SIZE  register file write data (registered).
- busy_vec  output  REG_NUM  scoreboard; bit r set while a load to register r is outstanding.

Behaviour:
- Reset (rst low, asynchronous):
  - write_reg=0, rd_addr=0, write_data=0.
  - busy_vec=0; FIFO emptied with pointers and count set to 0.
  - lsu_ready=0 while rst is low.
  - Reset mid-operation discards buffered and in-flight loads without producing writes.
- Write latency: the winning request in cycle N drives write_reg, rd_addr and write_data from edge N+1 for exactly one cycle. With no winner, write_reg=0 and rd_addr/write_data hold their previous values.
- Arbitration, fixed priority: ALU > FIFO head > direct LSU.
  - ALU writeback in the same cycle as an accepted LSU return: the LSU entry is pushed into the FIFO.
  - FIFO non-empty, no ALU request: the head is popped and written. A simultaneously accepted LSU return is pushed, so order is preserved.
  - FIFO empty, no ALU request, LSU accepted: written directly and the FIFO is untouched.
- lsu_ready = (count != FIFO_DEPTH) when out of reset. While the FIFO is full, lsu_ready=0 even in a cycle where a pop occurs; no bypass.
- Register 0 writes: a request with rd==0 wins arbitration and consumes its slot, but write_reg stays 0 for that slot.
- Scoreboard set:
  - Condition: iss_valid && !iss_stall && iss_long && iss_rd!=0.
  - Action: set busy_vec[iss_rd] on that edge.
- Scoreboard clear: clear busy_vec[r] on the edge that loads write_reg with an LSU-sourced write to r (from the FIFO or direct path).
- Scoreboard priority and scope:
  - If set and clear hit the same register on the same edge, set wins.
  - ALU writes never change busy_vec.
- iss_stall is combinational: iss_valid && (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]), with busy[0] treated as 0. It is 0 whenever iss_valid=0.
- busy_vec[0] is always 0.
- Data path: pass-through, no modification of data. Width is DATA_SIZE throughout.

Test Plan:
- Reset: rst low with random inputs, then release → write_reg=0, busy_vec=0, lsu_ready=0 during reset and 1 one cycle after release.
- Collision: alu(rd=5, 0x11) and lsu(rd=6, 0x22) in cycle N →
  - N+1: write x5=0x11.
  - N+2: write x6=0x22.
  - lsu_ready stays 1.
- Backpressure:
  - Stimulus: alu_valid held 3 cycles while LSU returns x7=0xA, x8=0xB, x9=0xC.
  - lsu_ready drops to 0 after two accepts; the third is held by the LSU.
  - After the ALU releases, writes occur in order x7, x8, x9.
- Scoreboard:
  - Issue a load with rd=10; the next issue with rs1=10 → iss_stall=1.
  - LSU returns x10 → busy_vec[10] clears on the write_reg edge, and iss_stall drops the same cycle.
- x0 handling:
  - Load issued with rd=0 → busy_vec unchanged.
  - LSU return to x0 → no write_reg pulse, and a slot is still consumed.
- Reset mid-operation: FIFO holding 2 entries with busy_vec[3] set, pull rst low → no further writes and busy_vec=0.
